bcd_addsub_seq: RTL and testbench
=================================

BCD_ADDSUB_SEQ -- requirements
Module: bcd_addsub_seq

Interface
REQ-001 Parameter NDIGITS, default 4, number of BCD digits per operand; legal range 1..16.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 in_a  input  4*NDIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-007 in_b  input  4*NDIGITS  operand B, packed BCD.
REQ-008 in_sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_f  output  4*NDIGITS  packed BCD result.
REQ-012 out_carry  output  1  add: decimal carry out; sub: 1 = no borrow (A>=B).
REQ-013 out_err  output  1  an input digit exceeded 9 (see Configuration).

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1; on in_valid=1, latch in_a, in_b and in_sub, clear the digit index, and go to RUN.
REQ-016 RUN: in_ready=0; process exactly one digit per cycle, LSD first; after digit NDIGITS-1 go to DONE.
REQ-017 Digit step: b' = sub ? 9-b : b; s = a+b'+c (5 bits); if s>9 then digit = (s+6)[3:0] and c=1, else digit = s[3:0] and c=0.
REQ-018 Initial carry SHALL be in_sub, so subtraction forms the ten's complement: out_f = (A-B) mod 10^NDIGITS.
REQ-019 out_valid SHALL assert exactly NDIGITS cycles after the accept edge.
REQ-020 DONE: out_valid=1; out_f, out_carry and out_err SHALL be stable until out_ready=1.
REQ-021 DONE with out_ready=1: return to IDLE on the next edge; a new operand SHALL NOT be accepted on that same edge.
REQ-022 in_valid while in RUN or DONE SHALL be ignored; inputs change freely outside the accept edge.
REQ-023 Throughput: at most one operation per NDIGITS+2 cycles.
REQ-024 out_f, out_carry and out_err SHALL be 0 except when out_valid=1.

Reset
REQ-025 rst=1 SHALL force IDLE, in_ready=1 on the next cycle, out_valid=0, out_f=0, out_carry=0, out_err=0, and clear the index and carry.
REQ-026 rst asserted mid-RUN or in DONE SHALL abandon the operation; no out_valid for it is ever produced.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-028 Macro BCD_DIGIT_CHECK_EN: when defined, out_err = 1 if any latched digit of A or B is greater than 9; arithmetic still follows REQ-017.
REQ-029 Without BCD_DIGIT_CHECK_EN, out_err SHALL be constant 0 and no checking logic SHALL be present; invalid digits yield the REQ-017 result unflagged.

Verification (NDIGITS=4)
REQ-030 add 9999+0001 -> out_f=0000, out_carry=1, out_valid 4 cycles after accept.
REQ-031 add 1234+5678 -> 6912, carry 0; sub 5000-0001 -> 4999, carry 1; sub 0001-0002 -> 9999, carry 0.
REQ-032 out_ready held low 3 cycles in DONE -> out_valid and out_f stable for all 3; in_valid pulses during RUN and DONE are ignored.
REQ-033 rst on the 2nd RUN cycle -> out_valid never rises, in_ready=1 the next cycle; a fresh 0005+0005 then gives 0010, carry 0.
REQ-034 BCD_DIGIT_CHECK_EN defined, A=0x00A0 -> out_err=1; macro undefined, same stimulus -> out_err=0.

Source files
------------

// File: rtl/bcd_addsub_seq.sv
// bcd_addsub_seq: sequential packed-BCD adder/subtractor.
// Processes one decimal digit per cycle, least significant digit first.
// Subtraction adds the nine's complement of B plus an initial carry of 1,
// which gives (A - B) mod 10^NDIGITS. In that case a carry out of 1 means no borrow.
//
// Optional feature: define BCD_DIGIT_CHECK_EN to flag latched operand digits
// greater than 9 on out_err. When the macro is undefined, out_err is tied to 0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     operand handshake (in_a, in_b, in_sub)
//   in_a, in_b            packed BCD operands, digit 0 in bits [3:0]
//   in_sub                0 = A+B, 1 = A-B
//   out_valid/out_ready   result handshake
//   out_f                 packed BCD result
//   out_carry             add: decimal carry; sub: 1 = no borrow
//   out_err               invalid input digit seen (only with BCD_DIGIT_CHECK_EN)
module bcd_addsub_seq #(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NDIGITS-1:0] in_a,
    input  logic [4*NDIGITS-1:0] in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NDIGITS-1:0] out_f,
    output logic                 out_carry,
    output logic                 out_err
);

    localparam int unsigned W  = 4 * NDIGITS;
    localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            sub_q, sub_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    acc_q, acc_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_f_q, out_f_d;
    logic            out_carry_q, out_carry_d;

    // Single-digit BCD step on the current least significant operand digits
    logic [3:0]      a_dig, b_dig, b_eff, dig;
    logic [4:0]      sum;
    logic            c_next;
    logic [W-1:0]    acc_next;

    always_comb begin
        a_dig  = a_q[3:0];
        b_dig  = b_q[3:0];
        b_eff  = sub_q ? 4'(4'd9 - b_dig) : b_dig;
        sum    = 5'(a_dig) + 5'(b_eff) + 5'(carry_q);
        if (sum > 5'd9) begin
            dig    = 4'(sum + 5'd6);
            c_next = 1'b1;
        end else begin
            dig    = sum[3:0];
            c_next = 1'b0;
        end
        // Result digits enter at the top and shift down, so digit 0 ends up in [3:0]
        acc_next = (acc_q >> 4) | (W'(dig) << (W - 4));
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic err_acc_q, err_acc_d;
    logic out_err_q, out_err_d;
    logic err_next;

    always_comb begin
        err_next = err_acc_q | (a_dig > 4'd9) | (b_dig > 4'd9);
    end
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_f_d     = out_f_q;
        out_carry_d = out_carry_q;
`ifdef BCD_DIGIT_CHECK_EN
        err_acc_d   = err_acc_q;
        out_err_d   = out_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = in_a;
                    b_d       = in_b;
                    sub_d     = in_sub;
                    idx_d     = '0;
                    carry_d   = in_sub;
                    acc_d     = '0;
`ifdef BCD_DIGIT_CHECK_EN
                    err_acc_d = 1'b0;
`endif
                    state_d   = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = c_next;
                acc_d   = acc_next;
                idx_d   = idx_q + IW'(1);
`ifdef BCD_DIGIT_CHECK_EN
                err_acc_d = err_next;
`endif
                if (idx_q == IW'(NDIGITS - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_f_d     = acc_next;
                    out_carry_d = c_next;
`ifdef BCD_DIGIT_CHECK_EN
                    out_err_d   = err_next;
`endif
                end
            end
            DONE: begin
                // Leaving DONE always lands in IDLE, so no accept can happen on this edge
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    out_f_d     = '0;
                    out_carry_d = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
                    out_err_d   = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_f_q     <= '0;
            out_carry_q <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_acc_q   <= 1'b0;
            out_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_f_q     <= out_f_d;
            out_carry_q <= out_carry_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_acc_q   <= err_acc_d;
            out_err_q   <= out_err_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_f     = out_f_q;
    assign out_carry = out_carry_q;
`ifdef BCD_DIGIT_CHECK_EN
    assign out_err   = out_err_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_addsub_seq.sv
// Directed testbench for bcd_addsub_seq with NDIGITS = 4.
module tb_bcd_addsub_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_f;
    logic        out_carry;
    logic        out_err;

    int errors = 0;
    int checks = 0;

`ifdef BCD_DIGIT_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    bcd_addsub_seq #(.NDIGITS(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_sub   (in_sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_f    (out_f),
        .out_carry(out_carry),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    // Present one operand set from IDLE; return edges from accept to out_valid (20 = timeout)
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                            output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    // Pulse out_ready for one edge
    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_f !== 16'h0000 || out_carry !== 1'b0 || out_err !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got f=%h c=%b e=%b want 0000 0 0", out_f, out_carry, out_err);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_add();
        int lat;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", in_ready); end
        start_op(16'h9999, 16'h0001, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        checks++; if (out_f !== 16'h0000 || out_carry !== 1'b1) begin
            errors++; $display("FAIL add_9999_0001: got f=%h c=%b want 0000 1", out_f, out_carry);
        end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", out_err); end
        release_result();
        start_op(16'h1234, 16'h5678, 1'b0, lat);
        checks++; if (lat !== 4 || out_f !== 16'h6912 || out_carry !== 1'b0) begin
            errors++; $display("FAIL add_1234_5678: got lat=%0d f=%h c=%b want 4 6912 0", lat, out_f, out_carry);
        end
        release_result();
    endtask

    task automatic test_sub();
        int lat;
        start_op(16'h5000, 16'h0001, 1'b1, lat);
        checks++; if (lat !== 4 || out_f !== 16'h4999 || out_carry !== 1'b1) begin
            errors++; $display("FAIL sub_5000_0001: got lat=%0d f=%h c=%b want 4 4999 1", lat, out_f, out_carry);
        end
        release_result();
        start_op(16'h0001, 16'h0002, 1'b1, lat);
        checks++; if (lat !== 4 || out_f !== 16'h9999 || out_carry !== 1'b0) begin
            errors++; $display("FAIL sub_0001_0002: got lat=%0d f=%h c=%b want 4 9999 0", lat, out_f, out_carry);
        end
        release_result();
    endtask

    task automatic test_stall();
        int n;
        // Accept 0042+0013, then keep in_valid high with other operands through RUN and DONE
        @(negedge clk);
        in_a = 16'h0042; in_b = 16'h0013; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_a = 16'h9999; in_b = 16'h9999; in_sub = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL stall_latency: got %0d want 4", n); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (out_valid !== 1'b1 || out_f !== 16'h0055 || out_carry !== 1'b0) begin
                errors++; $display("FAIL stall_hold_%0d: got v=%b f=%h c=%b want 1 0055 0", i, out_valid, out_f, out_carry);
            end
            @(posedge clk);
            #1;
        end
        // Release with in_valid still high: it must not be accepted on the same edge
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        checks++; if (out_f !== 16'h0000 || out_carry !== 1'b0) begin
            errors++; $display("FAIL stall_cleared: got f=%h c=%b want 0000 0", out_f, out_carry);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        bit seen;
        @(negedge clk);
        in_a = 16'h1111; in_b = 16'h2222; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);              // accept
        #1 in_valid = 1'b0;
        @(posedge clk);              // first RUN digit
        #1 rst = 1'b1;
        @(posedge clk);              // reset on second RUN cycle
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_state: got rdy=%b v=%b want 1 0", in_ready, out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid: got %b want 0", seen); end
        start_op(16'h0005, 16'h0005, 1'b0, lat);
        checks++; if (lat !== 4 || out_f !== 16'h0010 || out_carry !== 1'b0) begin
            errors++; $display("FAIL rst_mid_fresh: got lat=%0d f=%h c=%b want 4 0010 0", lat, out_f, out_carry);
        end
        release_result();
    endtask

    task automatic test_digit_err();
        int lat;
        // Digit 1 of A is 0xA: 10+0 -> digit 0 with carry, so arithmetic result is 0100
        start_op(16'h00A0, 16'h0000, 1'b0, lat);
        checks++; if (lat !== 4 || out_f !== 16'h0100 || out_carry !== 1'b0) begin
            errors++; $display("FAIL err_arith: got lat=%0d f=%h c=%b want 4 0100 0", lat, out_f, out_carry);
        end
        checks++; if (out_err !== EXP_ERR) begin errors++; $display("FAIL err_flag: got %b want %b", out_err, EXP_ERR); end
        release_result();
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b want 0", out_err); end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic [15:0] f1, f2;
        first = -1; second = -1; f1 = '0; f2 = '0;
        @(negedge clk);
        in_a = 16'h0999; in_b = 16'h0001; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                if (first < 0) begin first = k; f1 = out_f; end
                else if (second < 0) begin second = k; f2 = out_f; end
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (first !== 4 || second !== 10) begin
            errors++; $display("FAIL b2b_timing: got %0d,%0d want 4,10", first, second);
        end
        checks++; if (f1 !== 16'h1000 || f2 !== 16'h1000) begin
            errors++; $display("FAIL b2b_result: got %h,%h want 1000,1000", f1, f2);
        end
        repeat (4) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_stall();
        test_rst_mid();
        test_digit_err();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
